// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle register-machine CPU: opcodes,
// instruction field layout, default sizing and the unknown-bit helper.
package cpu_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int NUM_REGS    = 16;
    localparam int INSTR_WIDTH = 32;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 24;
    localparam int RS1_MSB = 23;
    localparam int RS1_LSB = 20;
    localparam int RS2_MSB = 19;
    localparam int RS2_LSB = 16;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Register windows used by the 2x2 matrix multiply (row-major).
    localparam int MAT_A_BASE = 0;
    localparam int MAT_B_BASE = 4;
    localparam int MAT_C_BASE = 8;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_LOADI  = 4'h1,
        OP_ADD    = 4'h2,
        OP_SUB    = 4'h3,
        OP_MUL    = 4'h4,
        OP_AND    = 4'h5,
        OP_OR     = 4'h6,
        OP_XOR    = 4'h7,
        OP_MOV    = 4'h8,
        OP_OUT    = 4'h9,
        OP_MATMUL = 4'hA
    } opcode_e;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [7:0] ignored;
        logic [7:0] imm;
    } instr_t;

    // Four-state check; a word with any X/Z bit must not touch state.
    function automatic logic has_unknown(input logic [INSTR_WIDTH-1:0] raw);
        return $isunknown(raw);
    endfunction

endpackage

// File: rtl/cpu_if.sv
// Instruction/result bundle between an instruction source and the CPU core.
interface cpu_if;
    import cpu_pkg::*;

    logic [INSTR_WIDTH-1:0] current_instruction;
    logic [DATA_WIDTH-1:0]  cpu_output;

    modport master (
        output current_instruction,
        input  cpu_output
    );

    modport slave (
        input  current_instruction,
        output cpu_output
    );
endinterface

// File: rtl/tensor_unit_2x2.sv
// Combinational 2x2 matrix product C = A*B, each element the sum of two
// unsigned products truncated to the element width.
module tensor_unit_2x2
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic [WIDTH-1:0] a00,
    input  logic [WIDTH-1:0] a01,
    input  logic [WIDTH-1:0] a10,
    input  logic [WIDTH-1:0] a11,
    input  logic [WIDTH-1:0] b00,
    input  logic [WIDTH-1:0] b01,
    input  logic [WIDTH-1:0] b10,
    input  logic [WIDTH-1:0] b11,
    output logic [WIDTH-1:0] c00,
    output logic [WIDTH-1:0] c01,
    output logic [WIDTH-1:0] c10,
    output logic [WIDTH-1:0] c11
);

    // Truncation commutes with add/multiply, so WIDTH-bit arithmetic is exact.
    always_comb begin
        c00 = (a00 * b00) + (a01 * b10);
        c01 = (a00 * b01) + (a01 * b11);
        c10 = (a10 * b00) + (a11 * b10);
        c11 = (a10 * b01) + (a11 * b11);
    end

endmodule

// File: rtl/cpu.sv
// Single-cycle register-machine CPU: one instruction per rising edge, inline
// ALU, 2x2 matrix multiply on R0..R7 into R8..R11, registered output port.
module cpu #(
    parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = cpu_pkg::NUM_REGS
) (
    input  logic                               clock_in,
    input  logic                               reset_in,
    input  logic [cpu_pkg::INSTR_WIDTH-1:0]    current_instruction,
    output logic [DATA_WIDTH-1:0]              cpu_output
);

    typedef logic [DATA_WIDTH-1:0] word_t;

    word_t regs_r [NUM_REGS] = '{default: '0};
    word_t out_r             = '0;

    cpu_pkg::instr_t instr_s;
    logic            valid_s;
    word_t           rs1_val_s;
    word_t           rs2_val_s;
    word_t           alu_s;
    logic            wr_en_s;
    logic            out_en_s;
    logic            mat_en_s;
    word_t           c00_s;
    word_t           c01_s;
    word_t           c10_s;
    word_t           c11_s;

    tensor_unit_2x2 #(
        .WIDTH (DATA_WIDTH)
    ) u_tensor (
        .a00 (regs_r[cpu_pkg::MAT_A_BASE + 0]),
        .a01 (regs_r[cpu_pkg::MAT_A_BASE + 1]),
        .a10 (regs_r[cpu_pkg::MAT_A_BASE + 2]),
        .a11 (regs_r[cpu_pkg::MAT_A_BASE + 3]),
        .b00 (regs_r[cpu_pkg::MAT_B_BASE + 0]),
        .b01 (regs_r[cpu_pkg::MAT_B_BASE + 1]),
        .b10 (regs_r[cpu_pkg::MAT_B_BASE + 2]),
        .b11 (regs_r[cpu_pkg::MAT_B_BASE + 3]),
        .c00 (c00_s),
        .c01 (c01_s),
        .c10 (c10_s),
        .c11 (c11_s)
    );

    // Decode and ALU; operands come straight from the array, so aliasing rd
    // with rs1/rs2 naturally sees the pre-edge values.
    always_comb begin
        instr_s   = cpu_pkg::instr_t'(current_instruction);
        valid_s   = !cpu_pkg::has_unknown(instr_s);
        rs1_val_s = regs_r[instr_s.rs1];
        rs2_val_s = regs_r[instr_s.rs2];
        alu_s     = '0;
        wr_en_s   = 1'b0;
        out_en_s  = 1'b0;
        mat_en_s  = 1'b0;
        if (valid_s) begin
            case (instr_s.opcode)
                cpu_pkg::OP_LOADI: begin
                    wr_en_s = 1'b1;
                    alu_s   = word_t'(instr_s.imm);
                end
                cpu_pkg::OP_ADD: begin
                    wr_en_s = 1'b1;
                    alu_s   = rs1_val_s + rs2_val_s;
                end
                cpu_pkg::OP_SUB: begin
                    wr_en_s = 1'b1;
                    alu_s   = rs1_val_s - rs2_val_s;
                end
                cpu_pkg::OP_MUL: begin
                    wr_en_s = 1'b1;
                    alu_s   = rs1_val_s * rs2_val_s;
                end
                cpu_pkg::OP_AND: begin
                    wr_en_s = 1'b1;
                    alu_s   = rs1_val_s & rs2_val_s;
                end
                cpu_pkg::OP_OR: begin
                    wr_en_s = 1'b1;
                    alu_s   = rs1_val_s | rs2_val_s;
                end
                cpu_pkg::OP_XOR: begin
                    wr_en_s = 1'b1;
                    alu_s   = rs1_val_s ^ rs2_val_s;
                end
                cpu_pkg::OP_MOV: begin
                    wr_en_s = 1'b1;
                    alu_s   = rs1_val_s;
                end
                cpu_pkg::OP_OUT: begin
                    out_en_s = 1'b1;
                end
                cpu_pkg::OP_MATMUL: begin
                    mat_en_s = 1'b1;
                end
                default: begin
                    wr_en_s  = 1'b0;
                    out_en_s = 1'b0;
                    mat_en_s = 1'b0;
                end
            endcase
        end else begin
            wr_en_s  = 1'b0;
            out_en_s = 1'b0;
            mat_en_s = 1'b0;
        end
    end

    // Architectural state update; reset wins over whatever instruction is presented.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
            out_r <= '0;
        end else begin
            if (wr_en_s) begin
                regs_r[instr_s.rd] <= alu_s;
            end
            if (mat_en_s) begin
                regs_r[cpu_pkg::MAT_C_BASE + 0] <= c00_s;
                regs_r[cpu_pkg::MAT_C_BASE + 1] <= c01_s;
                regs_r[cpu_pkg::MAT_C_BASE + 2] <= c10_s;
                regs_r[cpu_pkg::MAT_C_BASE + 3] <= c11_s;
            end
            if (out_en_s) begin
                out_r <= rs1_val_s;
            end
        end
    end

    assign cpu_output = out_r;

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed vector table plus randomized
// instructions checked against an arithmetic reference model.
module tb_cpu;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst;

    cpu_if bus ();

    cpu #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) dut (
        .clock_in            (clk),
        .reset_in            (rst),
        .current_instruction (bus.current_instruction),
        .cpu_output          (bus.cpu_output)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        rst;
        logic        chk;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int errors = 0;

    logic [7:0] m_regs [16];
    logic [7:0] m_out;

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2,
                                       input logic [7:0] imm);
        return {op, rd, rs1, rs2, 8'h00, imm};
    endfunction

    function automatic void add_vec(input logic [31:0] ins, input logic r,
                                    input logic c, input logic [7:0] e);
        vec_t v;
        v.instr = ins;
        v.rst   = r;
        v.chk   = c;
        v.exp   = e;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: cpu_output=%02h expected=%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the instruction set computed with plain integer arithmetic.
    task automatic model_step(input logic [31:0] ins, input logic r);
        int op, rd, rs1, rs2, a, b;
        logic [7:0] c [4];
        if (r) begin
            for (int k = 0; k < 16; k++) m_regs[k] = 8'h00;
            m_out = 8'h00;
        end else if (!$isunknown(ins)) begin
            op  = int'(ins[OPC_MSB:OPC_LSB]);
            rd  = int'(ins[RD_MSB:RD_LSB]);
            rs1 = int'(ins[RS1_MSB:RS1_LSB]);
            rs2 = int'(ins[RS2_MSB:RS2_LSB]);
            a   = int'(m_regs[rs1]);
            b   = int'(m_regs[rs2]);
            case (op)
                1:  m_regs[rd] = ins[IMM_MSB:IMM_LSB];
                2:  m_regs[rd] = 8'((a + b) % 256);
                3:  m_regs[rd] = 8'((a - b + 256) % 256);
                4:  m_regs[rd] = 8'((a * b) % 256);
                5:  m_regs[rd] = m_regs[rs1] & m_regs[rs2];
                6:  m_regs[rd] = m_regs[rs1] | m_regs[rs2];
                7:  m_regs[rd] = m_regs[rs1] ^ m_regs[rs2];
                8:  m_regs[rd] = m_regs[rs1];
                9:  m_out      = m_regs[rs1];
                10: begin
                    for (int i = 0; i < 2; i++) begin
                        for (int j = 0; j < 2; j++) begin
                            c[i*2+j] = 8'((int'(m_regs[i*2]) * int'(m_regs[4+j])
                                         + int'(m_regs[i*2+1]) * int'(m_regs[6+j])) % 256);
                        end
                    end
                    for (int k = 0; k < 4; k++) m_regs[8+k] = c[k];
                end
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic r);
        bus.current_instruction = ins;
        rst = r;
        @(posedge clk);
        #1;
        model_step(ins, r);
    endtask

    initial begin
        logic [31:0] ins;
        logic        r;
        logic [3:0]  op;

        rst = 1'b0;
        bus.current_instruction = 32'h0000_0000;
        for (int k = 0; k < 16; k++) m_regs[k] = 8'h00;
        m_out = 8'h00;

        #1;
        check("init_out", bus.cpu_output, 8'h00);

        // Reset with an instruction presented, then OUT R0
        add_vec(mk(4'h2, 4'h1, 4'h1, 4'h1, 8'h00), 1'b1, 1'b1, 8'h00);
        add_vec(mk(4'h9, 4'h0, 4'h0, 4'h0, 8'h00), 1'b0, 1'b1, 8'h00);
        // Load / add / out, output unchanged until the OUT edge
        add_vec(mk(4'h1, 4'h1, 4'h0, 4'h0, 8'h05), 1'b0, 1'b0, 8'h00);
        add_vec(mk(4'h1, 4'h2, 4'h0, 4'h0, 8'h03), 1'b0, 1'b0, 8'h00);
        add_vec(mk(4'h2, 4'h3, 4'h1, 4'h2, 8'h00), 1'b0, 1'b1, 8'h00);
        add_vec(mk(4'h9, 4'h0, 4'h3, 4'h0, 8'h00), 1'b0, 1'b1, 8'h08);
        add_vec(mk(4'h1, 4'h6, 4'h0, 4'h0, 8'h11), 1'b0, 1'b1, 8'h08);
        // Wrap-around arithmetic
        add_vec(mk(4'h1, 4'h1, 4'h0, 4'h0, 8'hFF), 1'b0, 1'b0, 8'h00);
        add_vec(mk(4'h1, 4'h2, 4'h0, 4'h0, 8'h02), 1'b0, 1'b0, 8'h00);
        add_vec(mk(4'h2, 4'h3, 4'h1, 4'h2, 8'h00), 1'b0, 1'b0, 8'h00);
        add_vec(mk(4'h3, 4'h4, 4'h2, 4'h1, 8'h00), 1'b0, 1'b0, 8'h00);
        add_vec(mk(4'h4, 4'h5, 4'h1, 4'h1, 8'h00), 1'b0, 1'b0, 8'h00);
        add_vec(mk(4'h9, 4'h0, 4'h3, 4'h0, 8'h00), 1'b0, 1'b1, 8'h01);
        add_vec(mk(4'h9, 4'h0, 4'h4, 4'h0, 8'h00), 1'b0, 1'b1, 8'h03);
        add_vec(mk(4'h9, 4'h0, 4'h5, 4'h0, 8'h00), 1'b0, 1'b1, 8'h01);
        // Logic ops and MOV
        add_vec(mk(4'h5, 4'h6, 4'h1, 4'h4, 8'h00), 1'b0, 1'b0, 8'h00);
        add_vec(mk(4'h6, 4'h7, 4'h2, 4'h4, 8'h00), 1'b0, 1'b0, 8'h00);
        add_vec(mk(4'h7, 4'h8, 4'h1, 4'h2, 8'h00), 1'b0, 1'b0, 8'h00);
        add_vec(mk(4'h8, 4'h9, 4'h8, 4'h0, 8'h00), 1'b0, 1'b0, 8'h00);
        add_vec(mk(4'h9, 4'h0, 4'h6, 4'h0, 8'h00), 1'b0, 1'b1, 8'h03);
        add_vec(mk(4'h9, 4'h0, 4'h7, 4'h0, 8'h00), 1'b0, 1'b1, 8'h03);
        add_vec(mk(4'h9, 4'h0, 4'h9, 4'h0, 8'h00), 1'b0, 1'b1, 8'hFD);
        // MATMUL: A=[1,2;3,4], B=[5,6;7,8]
        for (int k = 0; k < 8; k++) add_vec(mk(4'h1, 4'(k), 4'h0, 4'h0, 8'(k + 1)), 1'b0, 1'b0, 8'h00);
        add_vec(mk(4'hA, 4'hF, 4'h3, 4'h5, 8'h99), 1'b0, 1'b0, 8'h00);
        add_vec(mk(4'h9, 4'h0, 4'h8, 4'h0, 8'h00), 1'b0, 1'b1, 8'd19);
        add_vec(mk(4'h9, 4'h0, 4'h9, 4'h0, 8'h00), 1'b0, 1'b1, 8'd22);
        add_vec(mk(4'h9, 4'h0, 4'hA, 4'h0, 8'h00), 1'b0, 1'b1, 8'd43);
        add_vec(mk(4'h9, 4'h0, 4'hB, 4'h0, 8'h00), 1'b0, 1'b1, 8'd50);
        add_vec(mk(4'h9, 4'h0, 4'h0, 4'h0, 8'h00), 1'b0, 1'b1, 8'h01);
        add_vec(mk(4'h9, 4'h0, 4'h7, 4'h0, 8'h00), 1'b0, 1'b1, 8'h08);
        // NOP / illegal / unknown instructions change nothing
        add_vec(mk(4'h1, 4'h1, 4'h0, 4'h0, 8'h2A), 1'b0, 1'b0, 8'h00);
        add_vec(mk(4'hC, 4'h1, 4'h0, 4'h0, 8'h55), 1'b0, 1'b1, 8'h08);
        add_vec(mk(4'hF, 4'h1, 4'h1, 4'h1, 8'hFF), 1'b0, 1'b1, 8'h08);
        add_vec(32'hxxxx_xxxx, 1'b0, 1'b1, 8'h08);
        add_vec(mk(4'h0, 4'h1, 4'h2, 4'h3, 8'h66), 1'b0, 1'b1, 8'h08);
        add_vec(mk(4'h9, 4'h0, 4'h1, 4'h0, 8'h00), 1'b0, 1'b1, 8'h2A);
        add_vec(mk(4'h9, 4'h0, 4'h2, 4'h0, 8'h00), 1'b0, 1'b1, 8'h03);
        add_vec(mk(4'h9, 4'h0, 4'h8, 4'h0, 8'h00), 1'b0, 1'b1, 8'd19);
        // rd aliasing a source reads pre-edge values
        add_vec(mk(4'h2, 4'h1, 4'h1, 4'h1, 8'h00), 1'b0, 1'b0, 8'h00);
        add_vec(mk(4'h9, 4'h0, 4'h1, 4'h0, 8'h00), 1'b0, 1'b1, 8'h54);
        add_vec(mk(4'h3, 4'h2, 4'h2, 4'h1, 8'h00), 1'b0, 1'b0, 8'h00);
        add_vec(mk(4'h9, 4'h0, 4'h2, 4'h0, 8'h00), 1'b0, 1'b1, 8'hAF);
        // Mid-stream reset
        add_vec(mk(4'h1, 4'h1, 4'h0, 4'h0, 8'h77), 1'b0, 1'b0, 8'h00);
        add_vec(mk(4'h2, 4'h1, 4'h1, 4'h1, 8'h00), 1'b1, 1'b1, 8'h00);
        add_vec(mk(4'h9, 4'h0, 4'h1, 4'h0, 8'h00), 1'b0, 1'b1, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].instr, vecs[i].rst);
            if (vecs[i].chk) check($sformatf("dir%0d", i), bus.cpu_output, vecs[i].exp);
        end

        // Randomized stream, OUT-biased so register contents are observed often
        for (int n = 0; n < 800; n++) begin
            ins = $urandom();
            op  = ($urandom_range(0, 99) < 30) ? 4'h9 : 4'($urandom_range(0, 15));
            ins[OPC_MSB:OPC_LSB] = op;
            r = ($urandom_range(0, 39) == 0);
            step(ins, r);
            check("rand_out", bus.cpu_output, m_out);
        end

        for (int k = 0; k < 16; k++) begin
            step(mk(4'h9, 4'h0, 4'(k), 4'h0, 8'h00), 1'b0);
            check($sformatf("sweep_r%0d", k), bus.cpu_output, m_regs[k]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
